// File: rtl/jtag_dr_bridge_if.sv
// Word-stream handshake between the JTAG DR bridge and fabric logic.
// master = bridge side, slave = fabric consumer/producer side.
interface jtag_dr_bridge_if #(
    parameter int W = 32
);
    logic [W-1:0] rx_data;
    logic         rx_valid;
    logic         rx_ready;
    logic [W-1:0] tx_data;
    logic         tx_valid;
    logic         tx_ready;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output tx_data,
        output tx_valid,
        input  tx_ready
    );
endinterface

// File: rtl/jtag_dr_bridge.sv
// BSCANE2 USER-chain DR bridge: oversampled JTAG scans become a word
// stream on debug_clock; fabric words are returned on the next capture.
module jtag_dr_bridge #(
    parameter int                     JDATA_WIDTH = 32,
    parameter logic [JDATA_WIDTH-1:0] IDLE_WORD   = '0
) (
    input  logic             debug_clock,
    input  logic             debug_reset_n,
    input  logic             jtag_tck,
    input  logic             jtag_tdi,
    input  logic             jtag_sel,
    input  logic             jtag_shift,
    input  logic             jtag_capture,
    input  logic             jtag_update,
    output logic             jtag_tdo,
    jtag_dr_bridge_if.master bus,
    output logic             rx_overflow,
    output logic             frame_err,
    input  logic             err_clear
);

    localparam int W  = JDATA_WIDTH;
    localparam int CW = $clog2(W + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(W);
    localparam logic [CW-1:0] CNT_MAX  = CW'(W + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_COMMIT
    } state_t;

    logic [2:0] tck_q;
    logic [1:0] tdi_q;
    logic [1:0] sel_q;
    logic [1:0] shf_q;
    logic [1:0] cap_q;
    logic [1:0] upd_q;

    state_t        state_q, state_d;
    logic [W-1:0]  sr_q, sr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  tx_hold_q;
    logic          tx_full_q;
    logic          tdo_q;
    logic          ovf_q;
    logic          ferr_q;

    logic [W-1:0]  mem_q [2];
    logic          wr_q;
    logic          rd_q;
    logic [1:0]    fcnt_q;

    logic tck_rise, tck_fall;
    logic tdi_s, sel_s, shf_s, cap_s, upd_s;
    logic tx_take, commit;
    logic len_ok, fifo_full;
    logic push, pop, tx_load;
    logic ovf_set, ferr_set;
    logic [W-1:0] cap_word;

    always_ff @(posedge debug_clock or negedge debug_reset_n) begin
        if (!debug_reset_n) begin
            tck_q <= '0;
            tdi_q <= '0;
            sel_q <= '0;
            shf_q <= '0;
            cap_q <= '0;
            upd_q <= '0;
        end else begin
            tck_q <= {tck_q[1:0], jtag_tck};
            tdi_q <= {tdi_q[0], jtag_tdi};
            sel_q <= {sel_q[0], jtag_sel};
            shf_q <= {shf_q[0], jtag_shift};
            cap_q <= {cap_q[0], jtag_capture};
            upd_q <= {upd_q[0], jtag_update};
        end
    end

    assign tck_rise = tck_q[1] & ~tck_q[2];
    assign tck_fall = ~tck_q[1] & tck_q[2];
    assign tdi_s    = tdi_q[1];
    assign sel_s    = sel_q[1];
    assign shf_s    = shf_q[1];
    assign cap_s    = cap_q[1];
    assign upd_s    = upd_q[1];

    // Capture takes the pending tx word before any same-cycle load lands.
    assign cap_word = tx_full_q ? tx_hold_q : IDLE_WORD;

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        tx_take = 1'b0;
        commit  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (tck_rise && sel_s && cap_s) begin
                    sr_d    = cap_word;
                    tx_take = 1'b1;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (tck_rise) begin
                    if (!sel_s) begin
                        state_d = S_IDLE;
                    end else if (cap_s) begin
                        sr_d    = cap_word;
                        tx_take = 1'b1;
                        cnt_d   = '0;
                    end else if (upd_s) begin
                        state_d = S_COMMIT;
                    end else if (shf_s) begin
                        sr_d = {tdi_s, sr_q[W-1:1]};
                        if (cnt_q != CNT_MAX) begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
            end
            S_COMMIT: begin
                commit  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign len_ok    = (cnt_q == CNT_FULL);
    assign fifo_full = (fcnt_q == 2'd2);
    assign pop       = bus.rx_valid & bus.rx_ready;
    assign push      = commit & len_ok & (~fifo_full | pop);
    assign ovf_set   = commit & len_ok & fifo_full & ~pop;
    assign ferr_set  = commit & ~len_ok;
    assign tx_load   = bus.tx_valid & ~tx_full_q;

    always_ff @(posedge debug_clock or negedge debug_reset_n) begin
        if (!debug_reset_n) begin
            state_q   <= S_IDLE;
            sr_q      <= '0;
            cnt_q     <= '0;
            tx_hold_q <= '0;
            tx_full_q <= 1'b0;
            tdo_q     <= 1'b0;
            ovf_q     <= 1'b0;
            ferr_q    <= 1'b0;
            mem_q[0]  <= '0;
            mem_q[1]  <= '0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            fcnt_q    <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            if (tx_load) begin
                tx_hold_q <= bus.tx_data;
            end
            tx_full_q <= tx_load | (tx_full_q & ~tx_take);
            if (tck_fall && state_q != S_COMMIT) begin
                tdo_q <= sr_q[0];
            end
            ovf_q  <= ovf_set | (ovf_q & ~err_clear);
            ferr_q <= ferr_set | (ferr_q & ~err_clear);
            if (push) begin
                mem_q[wr_q] <= sr_q;
            end
            wr_q   <= wr_q ^ push;
            rd_q   <= rd_q ^ pop;
            fcnt_q <= fcnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

    assign jtag_tdo     = tdo_q;
    assign rx_overflow  = ovf_q;
    assign frame_err    = ferr_q;
    assign bus.rx_valid = (fcnt_q != 2'd0);
    assign bus.rx_data  = mem_q[rd_q];
    assign bus.tx_ready = ~tx_full_q;

endmodule
